// File: rtl/switch_box_cfg.sv
//------------------------------------------------------------------------------
// switch_box_cfg
//   FPGA routing switch box with four bidirectional pin sides. Each pin is
//   either released (Z) or driven from one pin on any side. The routing table
//   is loaded through a serial configuration chain into a shadow register. A
//   commit copies the validated shadow into the active routing table.
//
// Ports
//   clk          clock
//   rst          asynchronous reset, active-high
//   cfg_in       serial configuration data, sampled when cfg_en=1
//   cfg_en       shift enable
//   cfg_commit   copy shadow -> active (honoured only when cfg_full=1)
//   cfg_out      shadow bit 0, feeds the next box in the chain
//   cfg_full     a full table has been shifted since the last commit/reset
//   cfg_done     one-cycle pulse in the cycle after an accepted commit
//   cfg_err      sticky: rejected commit or invalid entry seen at commit
//   wtop/wbottom W_TB pins each
//   wleft/wright W_LR pins each
//
// Entry k (k = top[0..], bottom[0..], left[0..], right[0..]) sits at
// sh[k*CFG_W +: CFG_W]: bits [2:0] source side (0 Z, 1 top, 2 right,
// 3 bottom, 4 left), bits [CFG_W-1:3] source pin index.
//------------------------------------------------------------------------------
module switch_box_cfg #(
    parameter int W_TB  = 5,
    parameter int W_LR  = 4,
    parameter int IDX_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_in,
    input  logic            cfg_en,
    input  logic            cfg_commit,
    output logic            cfg_out,
    output logic            cfg_full,
    output logic            cfg_done,
    output logic            cfg_err,
    inout  wire [W_TB-1:0]  wtop,
    inout  wire [W_TB-1:0]  wbottom,
    inout  wire [W_LR-1:0]  wleft,
    inout  wire [W_LR-1:0]  wright
);

    localparam int CFG_W     = IDX_W + 3;
    localparam int N_ENT     = 2 * W_TB + 2 * W_LR;
    localparam int TOTAL     = N_ENT * CFG_W;
    localparam int CNT_W     = $clog2(TOTAL + 1);
    localparam int N_PIN_IDX = 2 ** IDX_W;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);

    localparam logic [2:0] SIDE_Z      = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [TOTAL-1:0]     r_sh;
    logic [TOTAL-1:0]     r_active;
    logic [TOTAL-1:0]     w_validated;
    logic                 w_any_bad;
    logic                 r_done;
    logic                 r_err;
    logic                 w_commit_ok;
    logic                 w_commit_bad;

    logic [2:0]           w_side [N_ENT];
    logic [IDX_W-1:0]     w_idx  [N_ENT];
    logic [N_ENT-1:0]     w_drv_en;
    logic [N_ENT-1:0]     w_src_val;
    logic [N_PIN_IDX-1:0] w_top_ext;
    logic [N_PIN_IDX-1:0] w_bottom_ext;
    logic [N_PIN_IDX-1:0] w_left_ext;
    logic [N_PIN_IDX-1:0] w_right_ext;

    //--------------------------------------------------------------------------
    // Destination side / index of entry k, following the shadow entry order.
    //--------------------------------------------------------------------------
    function automatic logic [2:0] dest_side(input int k);
        if (k < W_TB)                    return SIDE_TOP;
        else if (k < 2 * W_TB)           return SIDE_BOTTOM;
        else if (k < 2 * W_TB + W_LR)    return SIDE_LEFT;
        else                             return SIDE_RIGHT;
    endfunction

    function automatic int dest_idx(input int k);
        if (k < W_TB)                    return k;
        else if (k < 2 * W_TB)           return k - W_TB;
        else if (k < 2 * W_TB + W_LR)    return k - 2 * W_TB;
        else                             return k - 2 * W_TB - W_LR;
    endfunction

    // A Z entry is always acceptable; a sourced entry must name an existing
    // pin that is not the destination itself.
    function automatic logic entry_bad(input logic [CFG_W-1:0] e, input int k);
        logic [2:0] side;
        int         idx;
        int         width;
        side  = e[2:0];
        idx   = int'(e[CFG_W-1:3]);
        width = 0;
        case (side)
            SIDE_Z:                 return 1'b0;
            SIDE_TOP, SIDE_BOTTOM:  width = W_TB;
            SIDE_RIGHT, SIDE_LEFT:  width = W_LR;
            default:                return 1'b1;
        endcase
        return (idx >= width) || ((side == dest_side(k)) && (idx == dest_idx(k)));
    endfunction

    //--------------------------------------------------------------------------
    // Configuration FSM
    //--------------------------------------------------------------------------
    assign w_commit_ok  = cfg_commit && (r_state == ST_FULL);
    assign w_commit_bad = cfg_commit && (r_state != ST_FULL);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (cfg_en) begin
                    w_cnt_nxt   = CNT_ONE;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cfg_en) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                // Shifting while FULL is chain pass-through; cnt stays saturated.
                // A commit restarts the count, counting a simultaneous shift.
                if (cfg_commit) begin
                    w_cnt_nxt   = cfg_en ? CNT_ONE : '0;
                    w_state_nxt = cfg_en ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Commit snapshot: invalid entries and Z entries are both stored as 0.
    always_comb begin
        w_validated = '0;
        w_any_bad   = 1'b0;
        for (int k = 0; k < N_ENT; k++) begin
            if (entry_bad(r_sh[k*CFG_W +: CFG_W], k)) begin
                w_any_bad = 1'b1;
            end else if (r_sh[k*CFG_W +: 3] != SIDE_Z) begin
                w_validated[k*CFG_W +: CFG_W] = r_sh[k*CFG_W +: CFG_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the commit therefore sees the pre-shift
    // shadow even when cfg_en is high in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: both tables are reset, not just the control state: the
            // pins must be released the moment reset asserts.
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_sh     <= '0;
            r_active <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (cfg_en)      r_sh     <= {cfg_in, r_sh[TOTAL-1:1]};
            if (w_commit_ok) r_active <= w_validated;
            r_done <= w_commit_ok;
            r_err  <= r_err | w_commit_bad | (w_commit_ok & w_any_bad);
        end
    end

    assign cfg_out  = r_sh[0];
    assign cfg_full = (r_state == ST_FULL);
    assign cfg_done = r_done;
    assign cfg_err  = r_err;

    //--------------------------------------------------------------------------
    // Pin routing: purely combinational from the active table.
    //--------------------------------------------------------------------------
    // Side vectors are widened to 2**IDX_W so any stored index selects cleanly.
    always_comb begin
        w_top_ext                  = '0;
        w_bottom_ext               = '0;
        w_left_ext                 = '0;
        w_right_ext                = '0;
        w_top_ext[W_TB-1:0]        = wtop;
        w_bottom_ext[W_TB-1:0]     = wbottom;
        w_left_ext[W_LR-1:0]       = wleft;
        w_right_ext[W_LR-1:0]      = wright;
    end

    for (genvar k = 0; k < N_ENT; k++) begin : g_ent
        assign w_side[k]   = r_active[k*CFG_W +: 3];
        assign w_idx[k]    = r_active[k*CFG_W+3 +: IDX_W];
        assign w_drv_en[k] = (w_side[k] != SIDE_Z);
    end

    always_comb begin
        w_src_val = '0;
        for (int k = 0; k < N_ENT; k++) begin
            case (w_side[k])
                SIDE_TOP:    w_src_val[k] = w_top_ext[w_idx[k]];
                SIDE_RIGHT:  w_src_val[k] = w_right_ext[w_idx[k]];
                SIDE_BOTTOM: w_src_val[k] = w_bottom_ext[w_idx[k]];
                SIDE_LEFT:   w_src_val[k] = w_left_ext[w_idx[k]];
                default:     w_src_val[k] = 1'b0;
            endcase
        end
    end

    for (genvar i = 0; i < W_TB; i++) begin : g_tb_pins
        assign wtop[i]    = w_drv_en[i]        ? w_src_val[i]        : 1'bz;
        assign wbottom[i] = w_drv_en[W_TB + i] ? w_src_val[W_TB + i] : 1'bz;
    end

    for (genvar i = 0; i < W_LR; i++) begin : g_lr_pins
        assign wleft[i]  = w_drv_en[2*W_TB + i]        ? w_src_val[2*W_TB + i]        : 1'bz;
        assign wright[i] = w_drv_en[2*W_TB + W_LR + i] ? w_src_val[2*W_TB + W_LR + i] : 1'bz;
    end

endmodule

// File: tb/tb_switch_box_cfg.sv
//------------------------------------------------------------------------------
// tb_switch_box_cfg
//   Two chained switch boxes (A.cfg_out -> B.cfg_in). The reference model
//   keeps each shadow as a circular bit buffer (oldest bit = cfg_out), a bit
//   counter, and the active routing as "pin p is driven from pin src" ids.
//   Pin ids follow the entry order: top 0-4, bottom 5-9, left 10-13,
//   right 14-17. Pins whose route is Z are driven by the bench; routed pins
//   are expected to follow their source chain.
//------------------------------------------------------------------------------
module tb_switch_box_cfg;

    localparam int CFG_W = 6;
    localparam int N_ENT = 18;
    localparam int TOTAL = 108;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_in_a = 1'b0;
    logic cfg_en = 1'b0;
    logic cfg_commit = 1'b0;
    logic a_out, a_full, a_done, a_err;
    logic b_out, b_full, b_done, b_err;

    wire [4:0] a_top, a_bot, b_top, b_bot;
    wire [3:0] a_left, a_right, b_left, b_right;
    logic [N_ENT-1:0] a_den = '0, a_dval = '0, b_den = '0, b_dval = '0;
    wire  [N_ENT-1:0] a_pins = {a_right, a_left, a_bot, a_top};
    wire  [N_ENT-1:0] b_pins = {b_right, b_left, b_bot, b_top};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 5; i++) begin : g_drv5
        assign a_top[i] = a_den[i]     ? a_dval[i]     : 1'bz;
        assign a_bot[i] = a_den[5 + i] ? a_dval[5 + i] : 1'bz;
        assign b_top[i] = b_den[i]     ? b_dval[i]     : 1'bz;
        assign b_bot[i] = b_den[5 + i] ? b_dval[5 + i] : 1'bz;
    end
    for (genvar i = 0; i < 4; i++) begin : g_drv4
        assign a_left[i]  = a_den[10 + i] ? a_dval[10 + i] : 1'bz;
        assign a_right[i] = a_den[14 + i] ? a_dval[14 + i] : 1'bz;
        assign b_left[i]  = b_den[10 + i] ? b_dval[10 + i] : 1'bz;
        assign b_right[i] = b_den[14 + i] ? b_dval[14 + i] : 1'bz;
    end

    switch_box_cfg u_a (
        .clk(clk), .rst(rst), .cfg_in(cfg_in_a), .cfg_en(cfg_en), .cfg_commit(cfg_commit),
        .cfg_out(a_out), .cfg_full(a_full), .cfg_done(a_done), .cfg_err(a_err),
        .wtop(a_top), .wbottom(a_bot), .wleft(a_left), .wright(a_right)
    );

    switch_box_cfg u_b (
        .clk(clk), .rst(rst), .cfg_in(a_out), .cfg_en(cfg_en), .cfg_commit(cfg_commit),
        .cfg_out(b_out), .cfg_full(b_full), .cfg_done(b_done), .cfg_err(b_err),
        .wtop(b_top), .wbottom(b_bot), .wleft(b_left), .wright(b_right)
    );

    // ---------------- reference model ----------------
    bit sbuf   [2][TOTAL];
    int head   [2];
    int cnt_m  [2];
    bit err_m  [2];
    bit done_m [2];
    int act_m  [2][N_ENT];   // -1 = Z, otherwise source pin id

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit sh_bit(input int b, input int j);
        return sbuf[b][(head[b] + j) % TOTAL];
    endfunction

    // Source pin id for (side, idx); -1 for Z, -2 for an impossible source.
    function automatic int src_of(input int side, input int idx);
        case (side)
            0:       return -1;
            1:       return (idx < 5) ? idx      : -2;
            2:       return (idx < 4) ? 14 + idx : -2;
            3:       return (idx < 5) ? 5 + idx  : -2;
            4:       return (idx < 4) ? 10 + idx : -2;
            default: return -2;
        endcase
    endfunction

    function automatic logic [5:0] enc(input int p);
        if (p < 5)       return {3'(p), 3'd1};
        else if (p < 10) return {3'(p - 5), 3'd3};
        else if (p < 14) return {3'(p - 10), 3'd4};
        else             return {3'(p - 14), 3'd2};
    endfunction

    function automatic logic pin_val(input int b, input int p);
        return (b != 0) ? b_pins[p] : a_pins[p];
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            head[b] = 0; cnt_m[b] = 0; err_m[b] = 0; done_m[b] = 0;
            for (int i = 0; i < TOTAL; i++) sbuf[b][i] = 0;
            for (int k = 0; k < N_ENT; k++) act_m[b][k] = -1;
        end
    endtask

    task automatic apply_box(input int b, input bit en, input bit din, input bit commit);
        int side, idx, s;
        done_m[b] = 0;
        if (commit && cnt_m[b] == TOTAL) begin
            for (int k = 0; k < N_ENT; k++) begin
                side = sh_bit(b, k*CFG_W) + 2*sh_bit(b, k*CFG_W+1) + 4*sh_bit(b, k*CFG_W+2);
                idx  = sh_bit(b, k*CFG_W+3) + 2*sh_bit(b, k*CFG_W+4) + 4*sh_bit(b, k*CFG_W+5);
                s = src_of(side, idx);
                if (s == k) s = -2;
                if (s == -2) begin
                    err_m[b] = 1;
                    act_m[b][k] = -1;
                end else begin
                    act_m[b][k] = s;
                end
            end
            done_m[b] = 1;
            cnt_m[b]  = 0;
        end else if (commit) begin
            err_m[b] = 1;
        end
        if (en) begin
            sbuf[b][head[b]] = din;
            head[b] = (head[b] + 1) % TOTAL;
            if (cnt_m[b] < TOTAL) cnt_m[b]++;
        end
    endtask

    task automatic check_flags();
        check("a_out",  a_out,  sbuf[0][head[0]]);
        check("a_full", a_full, cnt_m[0] == TOTAL);
        check("a_done", a_done, done_m[0]);
        check("a_err",  a_err,  err_m[0]);
        check("b_out",  b_out,  sbuf[1][head[1]]);
        check("b_full", b_full, cnt_m[1] == TOTAL);
        check("b_done", b_done, done_m[1]);
        check("b_err",  b_err,  err_m[1]);
    endtask

    // One clock with the given inputs; entered and left at posedge+1.
    task automatic cycle(input bit en, input bit din, input bit commit);
        bit a_old;
        cfg_en = en; cfg_in_a = din; cfg_commit = commit;
        @(posedge clk); #1;
        a_old = sbuf[0][head[0]];
        apply_box(0, en, din, commit);
        apply_box(1, en, a_old, commit);
        cfg_en = 0; cfg_in_a = 0; cfg_commit = 0;
        check_flags();
    endtask

    // Bench drives every pin the model says is Z with random data, then
    // checks every pin against its resolved source chain.
    task automatic check_pins(input int b);
        logic [N_ENT-1:0] den, dval;
        logic v [N_ENT];
        den  = '0;
        dval = N_ENT'($urandom);
        for (int p = 0; p < N_ENT; p++) if (act_m[b][p] < 0) den[p] = 1'b1;
        if (b == 0) begin a_den = den; a_dval = dval; end
        else        begin b_den = den; b_dval = dval; end
        #1;
        for (int p = 0; p < N_ENT; p++) v[p] = dval[p];
        repeat (N_ENT)
            for (int p = 0; p < N_ENT; p++) if (act_m[b][p] >= 0) v[p] = v[act_m[b][p]];
        for (int p = 0; p < N_ENT; p++) check($sformatf("pin_b%0d_p%0d", b, p), pin_val(b, p), v[p]);
        if (b == 0) a_den = '0; else b_den = '0;
    endtask

    task automatic shift_img(input logic [TOTAL-1:0] img, input int lo, input int hi, input bit commit_first);
        for (int i = lo; i < hi; i++) cycle(1'b1, img[i], commit_first && (i == lo));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_flags();
        @(posedge clk); #1;
        rst = 1'b0;
        check_flags();
    endtask

    // Random loop-free routing: pins are visited in a random order and may
    // only source from a pin visited earlier; some entries are made invalid.
    task automatic gen_image(output logic [TOTAL-1:0] img);
        int order [N_ENT];
        int j, t, r, k;
        logic [5:0] e;
        for (int i = 0; i < N_ENT; i++) order[i] = i;
        for (int i = N_ENT - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i)); t = order[i]; order[i] = order[j]; order[j] = t;
        end
        img = '0;
        for (int p = 0; p < N_ENT; p++) begin
            k = order[p];
            r = int'($urandom_range(0, 9));
            if (p == 0 || r < 3) begin
                e = {3'($urandom_range(0, 7)), 3'd0};
            end else if (r == 3) begin
                case ($urandom_range(0, 3))
                    0:       e = {3'($urandom_range(0, 7)), 3'($urandom_range(5, 7))};
                    1:       e = {3'($urandom_range(5, 7)), 3'd3};
                    2:       e = {3'($urandom_range(4, 7)), 3'd2};
                    default: e = enc(k);
                endcase
            end else begin
                e = enc(order[$urandom_range(0, p - 1)]);
            end
            img[k*CFG_W +: CFG_W] = e;
        end
    endtask

    initial begin
        logic [TOTAL-1:0] img, img2;
        int mode, cut;
        model_reset();

        // Reset: everything released and flags low, held over 3 clocks.
        #2;
        check_flags();
        check_pins(0);
        check_pins(1);
        repeat (3) @(posedge clk);
        #1;
        check_flags();
        rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        check_pins(0);
        check_pins(1);

        // Single route: top[0] from left[2].
        img = '0;
        img[5:0] = 6'b010_100;
        shift_img(img, 0, TOTAL, 1'b0);
        check("full_after_load", a_full, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        a_den = '0; a_den[12] = 1'b1; a_dval[12] = 1'b1;
        #1;
        check("route_hi", a_top[0], 1'b1);
        a_dval[12] = 1'b0;
        #1;
        check("route_lo", a_top[0], 1'b0);
        a_den = '0;
        check_pins(0);
        check_pins(1);
        cycle(1'b0, 1'b0, 1'b0);

        // Early commit is rejected and leaves routing alone.
        gen_image(img);
        shift_img(img, 0, 50, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check("early_err", a_err, 1'b1);
        check_pins(0);
        shift_img(img, 50, TOTAL, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check_pins(0);
        check_pins(1);

        // Invalid entries: top[1] from right[5], bottom[3] from itself.
        do_reset();
        img = '0;
        img[1*CFG_W +: CFG_W]  = 6'b101_010;
        img[8*CFG_W +: CFG_W]  = 6'b011_011;
        img[14*CFG_W +: CFG_W] = enc(1);
        img[11*CFG_W +: CFG_W] = enc(8);
        img[0*CFG_W +: CFG_W]  = enc(13);
        shift_img(img, 0, TOTAL, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check("invalid_err", a_err, 1'b1);
        check_pins(0);

        // Chain: B's image first, then A's; A stays FULL while passing bits on.
        do_reset();
        gen_image(img2);
        gen_image(img);
        shift_img(img2, 0, TOTAL, 1'b0);
        shift_img(img, 0, 6, 1'b0);
        check("chain_a_full", a_full, 1'b1);
        shift_img(img, 6, TOTAL, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check_pins(0);
        check_pins(1);

        // Asynchronous reset in the middle of a load.
        gen_image(img);
        shift_img(img, 0, 60, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_flags();
        check_pins(0);
        check_pins(1);
        @(posedge clk); #1;
        rst = 1'b0;
        shift_img(img, 0, TOTAL, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check_pins(0);
        check_pins(1);

        // Random images with commit alone, commit+shift, and early commits.
        gen_image(img);
        shift_img(img, 0, TOTAL, 1'b0);
        for (int it = 0; it < 8; it++) begin
            gen_image(img2);
            mode = int'($urandom_range(0, 2));
            if (mode == 1) begin
                cycle(1'b1, img2[0], 1'b1);
                check_pins(0);
                check_pins(1);
                shift_img(img2, 1, TOTAL, 1'b0);
            end else begin
                cycle(1'b0, 1'b0, 1'b1);
                check_pins(0);
                check_pins(1);
                if (mode == 2) begin
                    cut = int'($urandom_range(1, TOTAL - 1));
                    shift_img(img2, 0, cut, 1'b0);
                    cycle(1'b0, 1'b0, 1'b1);
                    shift_img(img2, cut, TOTAL, 1'b0);
                end else begin
                    shift_img(img2, 0, TOTAL, 1'b0);
                end
            end
        end
        cycle(1'b0, 1'b0, 1'b1);
        check_pins(0);
        check_pins(1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
